wb_bypass_stage: RTL
====================

# wb_bypass_stage

Writeback/bypass pipeline between the execution lanes and the operand bypass network. Registers four lanes of execution results, drives the register-file write ports and the seven bypass buses consumed by the operand-forwarding stage, and squashes results belonging to mispredicted branches. Stage 1 feeds bypass buses 0..3 and the write ports. Stage 2 holds lanes 0..2 one extra cycle to cover register-file write-to-read latency and feeds buses 4..6.

## Interface
- WIDTH_REG, 5, physical register index width
- WIDTH_BRM, 4, branch-mask width (one bit per in-flight branch)
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_res0..i_res3  input  1+WIDTH_BRM+WIDTH_REG+32 each  lane result {VAL, BRMASK, RD, DATA}
- i_brkill  input  WIDTH_BRM  mispredicted-branch mask (0 or one-hot)
- i_brok  input  WIDTH_BRM  correctly-resolved-branch mask (any bits)
- o_bypass0..o_bypass3  output  33+WIDTH_REG each  {VAL, RD, DATA}, stage 1 of lanes 0..3
- o_bypass4..o_bypass6  output  33+WIDTH_REG each  {VAL, RD, DATA}, stage 2 of lanes 0..2
- o_wr0..o_wr3  output  33+WIDTH_REG each  register-file write {WE, RD, DATA}, stage 1 of lanes 0..3

## Operation
- No stall and no backpressure. Every cycle, all entries advance one stage.
- Stage 1 capture (lane k): VAL1 <= VAL & (RD != 0) & ~|(BRMASK & i_brkill); MASK1 <= BRMASK & ~i_brok; RD1, DATA1 <= RD, DATA.
- Stage 2 capture (lanes 0..2): VAL2 <= VAL1 & ~|(MASK1 & i_brkill); MASK2 <= MASK1 & ~i_brok; RD2, DATA2 <= RD1, DATA1.
- Output gating is combinational:
  - o_bypassk.VAL = VAL1 & ~|(MASK1 & i_brkill).
  - o_wrk.WE uses the same gating.
  - o_bypass(4+k).VAL = VAL2 & ~|(MASK2 & i_brkill).
  - A squashed result is never forwarded or written, even in the kill cycle.
- RD and DATA are passed unmodified.
- When VAL is 0, RD and DATA are don't-care, but they are still registered.
- RD == 0 is never valid (physical register 0 is hard-wired).
- i_brkill and i_brok carrying the same bit in the same cycle: kill takes priority.
- Duplicate RD across lanes is not checked. Lane priority is resolved downstream by the higher-indexed bus.

## Timing
- Result at lane input in cycle t: appears on o_bypassk and o_wrk in cycle t+1, and on o_bypass(4+k) in cycle t+2.
- Kill in cycle t: masks matching outputs in cycle t and prevents matching entries from advancing into cycle t+1.
- Brok in cycle t: takes effect on the masks captured at the t+1 edge.
- Reset asserted at an edge:
  - All VAL1/VAL2 are cleared to 0, and MASK, RD and DATA to 0.
  - From the next cycle all outputs read 0 until new results arrive.
  - Reset mid-stream discards every in-flight result.
- Lane inputs presented during the reset cycle are dropped.

## Configuration
- Macro `WB_BYPASS_STAGE2_EN`.
- Defined: stage 2 registers are present and o_bypass4..6 behave as above.
- Undefined:
  - Stage 2 registers are not instantiated.
  - o_bypass4..6 are tied to all-zero (VAL = 0).
  - Stage 1 behaviour is unchanged.

## Test plan
- Basic latency: lane0 {VAL=1, mask=0, RD=7, DATA=0xDEADBEEF} at t. Expect:
  - o_bypass0 = {1, 7, 0xDEADBEEF} and o_wr0.WE=1 at t+1.
  - o_bypass4 = same at t+2.
  - Both VAL=0 at t+3.
- Zero destination: lane2 {VAL=1, RD=0, DATA=5} -> o_bypass2.VAL=0, o_wr2.WE=0, o_bypass6.VAL=0.
- Kill paths:
  - Lane1 with mask=0b0100 at t and i_brkill=0b0100 at t -> o_bypass1.VAL=0 at t+1.
  - Same entry killed at t+1 instead -> o_bypass1.VAL=0 at t+1 (combinational) and o_bypass5.VAL=0 at t+2.
  - Non-matching kill 0b0001 -> both valid.
- Resolve then kill: lane0 mask=0b0010, i_brok=0b0010 at t, i_brkill=0b0010 at t+1 -> o_bypass0.VAL=1 at t+1 and o_bypass4.VAL=1 at t+2.
- Reset mid-stream: lanes 0..3 all valid at t, i_rst=1 at t+1 -> all outputs VAL=0 at t+2 and t+3, and data fields 0.
- Macro off: rerun the basic-latency test -> o_bypass4 = all-zero at t+2, o_bypass0 unchanged.

Source files
------------

// File: rtl/wb_bypass_stage_if.sv
// Bundles the lane results, branch resolution masks, bypass buses and register-file
// write ports of the writeback/bypass stage. Master drives lanes and masks; slave is the stage.
interface wb_bypass_stage_if #(
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_BRM = 4
);
    localparam int RES_W = 1 + WIDTH_BRM + WIDTH_REG + 32;
    localparam int BUS_W = 33 + WIDTH_REG;

    // Lane result: {VAL, BRMASK, RD, DATA}
    logic [RES_W-1:0]     res    [4];
    logic [WIDTH_BRM-1:0] brkill;
    logic [WIDTH_BRM-1:0] brok;
    // Bypass bus / write port: {VAL|WE, RD, DATA}
    logic [BUS_W-1:0]     bypass [7];
    logic [BUS_W-1:0]     wr     [4];

    modport master (output res, brkill, brok, input bypass, wr);
    modport slave  (input res, brkill, brok, output bypass, wr);
endinterface

// File: rtl/wb_bypass_stage.sv
// Writeback/bypass stage: registers four lanes, drives RF writes and seven bypass buses; stage 2 under `WB_BYPASS_STAGE2_EN.
// Latency: lane input -> bypass0..3/wr0..3 one cycle, bypass4..6 two cycles; kills gate outputs combinationally.
// Backpressure: none, every entry advances one stage per cycle unconditionally.
module wb_bypass_stage #(
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_BRM = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    wb_bypass_stage_if.slave bus
);
    localparam int DATA_LO = 0;
    localparam int RD_LO   = 32;
    localparam int MASK_LO = 32 + WIDTH_REG;
    localparam int VAL_BIT = 32 + WIDTH_REG + WIDTH_BRM;

    logic                 res_val  [4];
    logic [WIDTH_BRM-1:0] res_mask [4];
    logic [WIDTH_REG-1:0] res_rd   [4];
    logic [31:0]          res_data [4];

    logic                 val1  [4];
    logic [WIDTH_BRM-1:0] mask1 [4];
    logic [WIDTH_REG-1:0] rd1   [4];
    logic [31:0]          data1 [4];
    logic                 live1 [4];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign res_val[k]  = bus.res[k][VAL_BIT];
        assign res_mask[k] = bus.res[k][MASK_LO +: WIDTH_BRM];
        assign res_rd[k]   = bus.res[k][RD_LO +: WIDTH_REG];
        assign res_data[k] = bus.res[k][DATA_LO +: 32];

        // A kill arriving this cycle must suppress the forward and the write at once.
        assign live1[k]      = val1[k] & ~|(mask1[k] & bus.brkill);
        assign bus.bypass[k] = {live1[k], rd1[k], data1[k]};
        assign bus.wr[k]     = {live1[k], rd1[k], data1[k]};
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_rst) begin
                val1[k]  <= 1'b0;
                mask1[k] <= '0;
                rd1[k]   <= '0;
                data1[k] <= '0;
            end else begin
                // p0 is hard-wired, so RD==0 never produces a valid result.
                val1[k]  <= res_val[k] & (res_rd[k] != '0) & ~|(res_mask[k] & bus.brkill);
                mask1[k] <= res_mask[k] & ~bus.brok;
                rd1[k]   <= res_rd[k];
                data1[k] <= res_data[k];
            end
        end
    end

`ifdef WB_BYPASS_STAGE2_EN
    logic                 val2  [3];
    logic [WIDTH_BRM-1:0] mask2 [3];
    logic [WIDTH_REG-1:0] rd2   [3];
    logic [31:0]          data2 [3];

    // Holds lanes 0..2 one more cycle to cover register-file write-to-read latency.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (i_rst) begin
                val2[k]  <= 1'b0;
                mask2[k] <= '0;
                rd2[k]   <= '0;
                data2[k] <= '0;
            end else begin
                val2[k]  <= live1[k];
                mask2[k] <= mask1[k] & ~bus.brok;
                rd2[k]   <= rd1[k];
                data2[k] <= data1[k];
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_stage2
        assign bus.bypass[4+k] = {val2[k] & ~|(mask2[k] & bus.brkill), rd2[k], data2[k]};
    end
`else
    for (genvar k = 0; k < 3; k++) begin : g_stage2_off
        assign bus.bypass[4+k] = '0;
    end
`endif
endmodule
